// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: groups the CPU request/response handshake and the memory_controller strobes.
// master = the access unit (bus initiator); slave = its environment (CPU requester + controller).
// Signals: req_* / resp_* on the CPU side, mem_* on the controller side.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_error;

    modport master (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  mem_rdata, mem_error,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output mem_rd, mem_wr, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output mem_rdata, mem_error,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  mem_rd, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Purpose: CPU load/store initiator for memory_controller; sub-word stores become read-modify-write.
// Latency: load RD_LAT+1, word store 2, sub-word store RD_LAT+2, misaligned/illegal 1 cycle after acceptance.
// Backpressure: req_ready only in IDLE; a request shown in any other state waits there until IDLE.
// Ports: clk, rst (async active-low), bus (mem_access_unit_if.master: req_*/resp_* CPU side, mem_* controller side).
module mem_access_unit #(
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_unit_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RMW_RD,
        S_RMW_WR,
        S_RESP
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(RD_LAT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [31:0] wdata_q;     // store data, replaced by the merged word after the RMW read
    logic [31:0] rdata_q;
    logic        err_q;

    logic        rd_phase;
    logic        wr_phase;
    logic        rd_last;
    logic        misaligned;
    logic [31:0] shifted;
    logic [31:0] load_val;
    logic [31:0] lane_mask;
    logic [31:0] merged;

    assign rd_phase = (state == S_RD) || (state == S_RMW_RD);
    assign wr_phase = (state == S_WR) || (state == S_RMW_WR);
    assign rd_last  = (cnt == CNT_LAST);

    always_comb begin
        misaligned = 1'b0;
        case (bus.req_size)
            2'b01:   misaligned = bus.req_addr[0];
            2'b10:   misaligned = |bus.req_addr[1:0];
            2'b11:   misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
    end

    // Lane extraction: alignment is already guaranteed, so shifting by the byte
    // offset puts the addressed byte/half at bit 0 for both sizes.
    always_comb begin
        shifted  = bus.mem_rdata >> {addr_q[1:0], 3'b000};
        load_val = bus.mem_rdata;
        case (size_q)
            2'b00:   load_val = {{24{signed_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = {{16{signed_q & shifted[15]}}, shifted[15:0]};
            default: load_val = bus.mem_rdata;
        endcase
    end

    always_comb begin
        lane_mask = (size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
        lane_mask = lane_mask << {addr_q[1:0], 3'b000};
        merged    = (bus.mem_rdata & ~lane_mask)
                  | ((wdata_q << {addr_q[1:0], 3'b000}) & lane_mask);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (misaligned)                 state_nxt = S_RESP;
                    else if (!bus.req_write)        state_nxt = S_RD;
                    else if (bus.req_size == 2'b10) state_nxt = S_WR;
                    else                            state_nxt = S_RMW_RD;
                end
            end
            S_RD:     if (rd_last) state_nxt = S_RESP;
            S_WR:     state_nxt = S_RESP;
            S_RMW_RD: if (rd_last) state_nxt = bus.mem_error ? S_RESP : S_RMW_WR;
            S_RMW_WR: state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            addr_q   <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (bus.req_valid) begin
                        addr_q   <= bus.req_addr;
                        size_q   <= bus.req_size;
                        signed_q <= bus.req_signed;
                        wdata_q  <= bus.req_wdata;
                        rdata_q  <= '0;
                        err_q    <= misaligned;
                    end
                end
                S_RD, S_RMW_RD: begin
                    cnt <= rd_last ? 4'd0 : cnt + 4'd1;
                    if (rd_last) begin
                        err_q <= bus.mem_error;
                        if (state == S_RD && !bus.mem_error) rdata_q <= load_val;
                        if (state == S_RMW_RD)               wdata_q <= merged;
                    end
                end
                S_WR, S_RMW_WR: err_q <= bus.mem_error;
                default: cnt <= '0;
            endcase
        end
    end

    // All outputs decode registered state only; req_ready is additionally held low during reset.
    assign bus.req_ready  = (state == S_IDLE) && rst;
    assign bus.mem_rd     = rd_phase;
    assign bus.mem_wr     = wr_phase;
    assign bus.mem_addr   = (state == S_IDLE) ? 32'd0 : {addr_q[31:2], 2'b00};
    assign bus.mem_wdata  = wr_phase ? wdata_q : 32'd0;
    assign bus.resp_valid = (state == S_RESP);
    assign bus.resp_rdata = (state == S_RESP) ? rdata_q : 32'd0;
    assign bus.resp_error = (state == S_RESP) && err_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed plus randomized load/store traffic against RD_LAT=1 and RD_LAT=3 units.
// A behavioural controller/memory model answers the bus; expected results come from byte-level rules.
module tb_mem_access_unit;
    logic clk;
    logic rst;
    logic sel;   // 0: observe RD_LAT=1 unit, 1: observe RD_LAT=3 unit

    logic        req_valid, req_write, req_signed, mem_error;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, mem_rdata;

    mem_access_unit_if bus1 ();
    mem_access_unit_if bus3 ();

    assign bus1.req_valid  = req_valid;   assign bus3.req_valid  = req_valid;
    assign bus1.req_write  = req_write;   assign bus3.req_write  = req_write;
    assign bus1.req_size   = req_size;    assign bus3.req_size   = req_size;
    assign bus1.req_signed = req_signed;  assign bus3.req_signed = req_signed;
    assign bus1.req_addr   = req_addr;    assign bus3.req_addr   = req_addr;
    assign bus1.req_wdata  = req_wdata;   assign bus3.req_wdata  = req_wdata;
    assign bus1.mem_rdata  = mem_rdata;   assign bus3.mem_rdata  = mem_rdata;
    assign bus1.mem_error  = mem_error;   assign bus3.mem_error  = mem_error;

    mem_access_unit #(.RD_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.master));
    mem_access_unit #(.RD_LAT(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3.master));

    logic        o_req_ready, o_resp_valid, o_resp_error, o_mem_rd, o_mem_wr;
    logic [31:0] o_resp_rdata, o_mem_addr, o_mem_wdata;
    assign o_req_ready  = sel ? bus3.req_ready  : bus1.req_ready;
    assign o_resp_valid = sel ? bus3.resp_valid : bus1.resp_valid;
    assign o_resp_error = sel ? bus3.resp_error : bus1.resp_error;
    assign o_resp_rdata = sel ? bus3.resp_rdata : bus1.resp_rdata;
    assign o_mem_rd     = sel ? bus3.mem_rd     : bus1.mem_rd;
    assign o_mem_wr     = sel ? bus3.mem_wr     : bus1.mem_wr;
    assign o_mem_addr   = sel ? bus3.mem_addr   : bus1.mem_addr;
    assign o_mem_wdata  = sel ? bus3.mem_wdata  : bus1.mem_wdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [16];
    logic [31:0] last_rdata, last_wdata;
    logic        last_err;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Issues one request at the current falling edge (unit must be idle), plays the
    // controller, then compares against byte-level expectations.
    task automatic run_req(input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic rd_err, input logic wr_err);
        logic [31:0] old_w, new_w, exp_rdata, exp_wdata, v, got_rdata;
        logic        misal, exp_err, got_err, got;
        logic [7:0]  wb [4];
        int exp_lat, exp_rd, exp_wr, lat, rd_cnt, wr_cnt, addr_bad, both_bad, nb, lane, rl;
        rl    = sel ? 3 : 1;
        old_w = mem[a[5:2]];
        new_w = old_w;
        nb    = (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
        lane  = int'(a[1:0]);
        misal = (sz == 2'b11) || (lane % nb != 0);
        exp_rdata = 0; exp_wdata = 0; exp_err = 0; exp_rd = 0; exp_wr = 0;
        if (misal) begin
            exp_err = 1; exp_lat = 1;
        end else if (!wr) begin
            exp_rd = rl; exp_lat = rl + 1; exp_err = rd_err;
            v = 0;
            for (int k = 0; k < nb; k++) v = v | (32'(old_w[8*(lane+k) +: 8]) << (8*k));
            if (sg && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
            exp_rdata = rd_err ? 32'd0 : v;
        end else begin
            for (int k = 0; k < 4; k++) wb[k] = old_w[8*k +: 8];
            for (int k = 0; k < nb; k++) wb[lane+k] = wd[8*k +: 8];
            exp_wdata = {wb[3], wb[2], wb[1], wb[0]};
            if (nb == 4) begin
                exp_wr = 1; exp_lat = 2; exp_err = wr_err;
            end else if (rd_err) begin
                exp_rd = rl; exp_lat = rl + 1; exp_err = 1;
            end else begin
                exp_rd = rl; exp_wr = 1; exp_lat = rl + 2; exp_err = wr_err;
            end
            if (exp_wr == 1 && !wr_err) new_w = exp_wdata;
        end

        req_write = wr; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        check("ready_idle", {31'b0, o_req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        got = 0; lat = 0; rd_cnt = 0; wr_cnt = 0; addr_bad = 0; both_bad = 0;
        got_rdata = 0; got_err = 0;
        for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
            @(negedge clk);
            mem_error = 1'b0; mem_rdata = $urandom;
            if (o_mem_rd && o_mem_wr) both_bad++;
            if ((o_mem_rd || o_mem_wr) && o_mem_addr !== {a[31:2], 2'b00}) addr_bad++;
            if (o_mem_rd) begin
                rd_cnt++; mem_rdata = mem[o_mem_addr[5:2]]; mem_error = rd_err;
            end
            if (o_mem_wr) begin
                wr_cnt++; last_wdata = o_mem_wdata; mem_error = wr_err;
                if (!wr_err) mem[o_mem_addr[5:2]] = o_mem_wdata;
            end
            if (o_resp_valid) begin
                got = 1; lat = cyc; got_rdata = o_resp_rdata; got_err = o_resp_error;
            end
        end
        last_rdata = got_rdata; last_err = got_err;
        check("resp_seen",  {31'b0, got},      32'd1);
        check("latency",    32'(lat),          32'(exp_lat));
        check("resp_rdata", got_rdata,         exp_rdata);
        check("resp_error", {31'b0, got_err},  {31'b0, exp_err});
        check("rd_cycles",  32'(rd_cnt),       32'(exp_rd));
        check("wr_cycles",  32'(wr_cnt),       32'(exp_wr));
        check("addr_held",  32'(addr_bad),     32'd0);
        check("rd_wr_excl", 32'(both_bad),     32'd0);
        if (exp_wr == 1) check("mem_wdata", last_wdata, exp_wdata);
        check("mem_word",   mem[a[5:2]],       new_w);
        @(negedge clk);
        mem_error = 1'b0;
        check("resp_one_cycle", {31'b0, o_resp_valid}, 32'd0);
        check("ready_after",    {31'b0, o_req_ready},  32'd1);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [31:0] r;
        int          rs_seen;
        sel = 0; rst = 1'b0;
        req_valid = 0; req_write = 0; req_size = 0; req_signed = 0; req_addr = 0; req_wdata = 0;
        mem_rdata = 0; mem_error = 0; last_rdata = 0; last_wdata = 0; last_err = 0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;

        #3;
        check("rst_ready",  {31'b0, o_req_ready},  32'd0);
        check("rst_mem_rd", {31'b0, o_mem_rd},     32'd0);
        check("rst_mem_wr", {31'b0, o_mem_wr},     32'd0);
        check("rst_resp",   {31'b0, o_resp_valid}, 32'd0);
        check("rst_addr",   o_mem_addr,            32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("ready_after_rst", {31'b0, o_req_ready}, 32'd1);
        @(negedge clk);

        // Directed cases at RD_LAT=1
        mem[0] = 32'hDEAD_BEEF;
        run_req(0, 2'b10, 0, 32'h0000_1000, 0, 0, 0);
        check("tp_load_word", last_rdata, 32'hDEAD_BEEF);
        mem[0] = 32'h80FF_0000;
        run_req(0, 2'b00, 1, 32'h0000_1003, 0, 0, 0);
        check("tp_sbyte", last_rdata, 32'hFFFF_FF80);
        run_req(0, 2'b00, 0, 32'h0000_1003, 0, 0, 0);
        check("tp_ubyte", last_rdata, 32'h0000_0080);
        run_req(0, 2'b01, 1, 32'h0000_1002, 0, 0, 0);
        check("tp_shalf", last_rdata, 32'hFFFF_80FF);
        mem[0] = 32'h1122_3344;
        run_req(1, 2'b00, 0, 32'h0000_1001, 32'h0000_00AB, 0, 0);
        check("tp_rmw_wdata", last_wdata, 32'h1122_AB44);
        run_req(0, 2'b01, 0, 32'h0000_1001, 0, 0, 0);
        check("tp_misal_err", {31'b0, last_err}, 32'd1);
        run_req(0, 2'b11, 0, 32'h0000_1000, 0, 0, 0);
        check("tp_illegal_err", {31'b0, last_err}, 32'd1);
        run_req(1, 2'b01, 0, 32'h0000_1006, 32'h0000_BEEF, 1, 0);
        check("tp_rmw_rd_err", {31'b0, last_err}, 32'd1);

        // Reset in the second read cycle of an RD_LAT=3 load
        sel = 1;
        reset_pulse();
        @(negedge clk);
        mem[1] = 32'hCAFE_F00D;
        req_write = 0; req_size = 2'b10; req_signed = 0; req_addr = 32'h0000_1004; req_valid = 1;
        @(posedge clk);
        #1 req_valid = 0;
        @(posedge clk);
        #2;
        check("rst_mid_rd_before", {31'b0, o_mem_rd}, 32'd1);
        rst = 1'b0;
        #1;
        check("rst_mid_rd_drop",  {31'b0, o_mem_rd},    32'd0);
        check("rst_mid_ready",    {31'b0, o_req_ready}, 32'd0);
        check("rst_mid_addr",     o_mem_addr,           32'd0);
        rs_seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (o_resp_valid) rs_seen++;
        end
        rst = 1'b1;
        #1;
        check("rst_mid_ready_rel", {31'b0, o_req_ready}, 32'd1);
        repeat (4) begin
            @(negedge clk);
            if (o_resp_valid || o_mem_rd) rs_seen++;
        end
        check("rst_mid_no_resp", 32'(rs_seen), 32'd0);
        run_req(0, 2'b10, 0, 32'h0000_1004, 0, 0, 0);
        check("rst_mid_reload", last_rdata, 32'hCAFE_F00D);

        // Randomized traffic, both latencies, back-to-back requests
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            reset_pulse();
            @(negedge clk);
            for (int n = 0; n < 40; n++) begin
                r = $urandom;
                run_req(r[0], r[2:1], r[3], {r[31:6], 6'($urandom_range(0, 63))}, $urandom,
                        ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- CPU-side bus initiator for memory_controller.
- Accepts load/store requests from the core over a valid/ready handshake.
- Drives the controller's read/write strobes, word-aligned address and write data; returns load data or an error.
- Converts byte and halfword stores into read-modify-write word sequences; rejects misaligned accesses without touching the bus.

Parameters:
RD_LAT, 1, cycles mem_rd is held before mem_rdata/mem_error are sampled (legal range 1..15)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
req_valid  input  1  CPU request present
req_ready  output  1  unit can accept a request (IDLE only)
req_write  input  1  1=store, 0=load
req_size  input  2  00=byte, 01=half, 10=word, 11=illegal
req_signed  input  1  sign-extend sub-word loads
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
resp_valid  output  1  one-cycle response strobe
resp_rdata  output  32  load result (0 for stores and errors)
resp_error  output  1  access failed, valid with resp_valid
mem_rd  output  1  to controller cpu_read_mem
mem_wr  output  1  to controller cpu_write_mem
mem_addr  output  32  {addr[31:2],2'b00}
mem_wdata  output  32  to controller idata_from_cpu
mem_rdata  input  32  from controller odata_to_cpu
mem_error  input  1  from controller error

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=0. req_ready=1 once rst=1; all other outputs 0. Any in-flight access is dropped; mem_rd/mem_wr fall immediately, with no response issued.
- All mem_* and resp_* outputs come from registers/state only; there is no combinational path from req_* to them.
- Little-endian lanes: byte lane = addr[1:0], half lane = addr[1].
- IDLE: req_ready=1. Request is accepted on the edge where req_valid=1, and addr/size/write/signed/wdata are latched. Next state:
  - misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size=11 -> RESP with error=1, no bus cycle;
  - load -> RD;
  - word store -> WR;
  - byte/half store -> RMW_RD.
- RD: mem_rd=1 for exactly RD_LAT cycles. On the last cycle, sample mem_rdata and mem_error. Extract the lane; zero- or sign-extend per req_signed; word passes through. Then -> RESP.
- WR: mem_wr=1 for one cycle with mem_wdata=latched wdata. Sample mem_error, then -> RESP.
- RMW_RD: same as RD. If mem_error=1 -> RESP with error=1 and no write. Otherwise merge the store lane into the read word, register it into mem_wdata, and -> RMW_WR.
- RMW_WR: mem_wr=1 for one cycle with the merged word. Sample mem_error, then -> RESP.
- RESP: resp_valid=1 for exactly one cycle; resp_rdata and resp_error are held valid only in that cycle. Then -> IDLE. resp_rdata=0 when error=1 or the access is a store.
- req_ready=0 in every state except IDLE. req_valid outside IDLE is ignored; the CPU must hold its request.
- mem_addr is held stable for the whole access, including both RMW phases. It is 0 in IDLE.
- Never mem_rd and mem_wr in the same cycle.
- Latency, counted from the acceptance edge:
  - load: resp_valid in cycle RD_LAT+1;
  - word store: cycle 2;
  - sub-word store: cycle RD_LAT+2;
  - misaligned/illegal: cycle 1.
- Back-to-back: a new request can be accepted in the IDLE cycle right after RESP, giving one idle cycle minimum between accesses.

Test Plan:
- RD_LAT=1; load word 0x0000_1000, mem_rdata=0xDEADBEEF -> mem_rd high 1 cycle, mem_addr=0x1000, resp_valid next cycle with rdata=0xDEADBEEF, error=0.
- Signed byte load at 0x1003, mem_rdata=0x80FF_0000 -> rdata=0xFFFF_FF80; unsigned -> 0x0000_0080; signed half at 0x1002 -> 0xFFFF_80FF.
- Byte store 0xAB at 0x1001, memory word 0x1122_3344 -> mem_rd then mem_wr, mem_wdata=0x1122_AB44, resp_valid at cycle RD_LAT+2, error=0.
- Half load at 0x1001 and size=11 request -> no mem_rd/mem_wr, resp_valid in cycle 1 with error=1, rdata=0.
- Half store with mem_error=1 during read phase -> mem_wr never asserted, resp_error=1.
- RD_LAT=3 load; assert rst=0 in the second mem_rd cycle -> mem_rd drops asynchronously, no resp_valid, req_ready=1 after release; next load completes normally.
